// File: rtl/design_sel_sequencer_if.sv
// -----------------------------------------------------------------------------
// design_sel_sequencer_if
//   Request/response handshake between a select source (config register or
//   housekeeping pins) and the design-select sequencer.
//
//   Signals:
//     req_valid  requester -> sequencer  select-change request
//     req_sel    requester -> sequencer  requested design (0..7)
//     req_ready  sequencer -> requester  high only while the sequencer is in RUN
//     resp_valid sequencer -> requester  one-cycle completion / refusal pulse
//     resp_err   sequencer -> requester  qualifies resp_valid, 1 = refused
//
//   Modports:
//     master  the select source
//     slave   the sequencer
// -----------------------------------------------------------------------------
interface design_sel_sequencer_if;
   logic       req_valid;
   logic [2:0] req_sel;
   logic       req_ready;
   logic       resp_valid;
   logic       resp_err;

   modport master (
      output req_valid,
      output req_sel,
      input  req_ready,
      input  resp_valid,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_sel,
      output req_ready,
      output resp_valid,
      output resp_err
   );
endinterface

// File: rtl/design_sel_sequencer.sv
// -----------------------------------------------------------------------------
// design_sel_sequencer
//   Run-time owner of the 3-bit design select and the shared design reset that
//   feed the multi-design IO mux. Every select change (or restart) walks the
//   same sequence so that no design ever drives pads while the mux is moving:
//
//     RUN -> QUIESCE (GUARD_CYCLES, old select, pads killed, design in reset)
//         -> SWITCH  (1 cycle, new select loaded)
//         -> HOLD    (HOLD_CYCLES, new select, pads killed, design in reset)
//         -> RUN     (reset released, pads enabled, response issued)
//
//   Ports:
//     clk_i         system clock
//     rst           synchronous active-high reset
//     bus           request/response handshake (slave modport)
//     soft_rst      restart the current design without changing the select
//     design_sel    mux select
//     design_rst_n  active-low reset to all designs
//     io_quiet      1 forces every io_oe low in the mux
//     busy          1 whenever the sequencer is not in RUN
//     lock          (only with DESIGN_SEL_SEQUENCER_LOCK_EN) sticky refusal
//
//   Optional feature macro: DESIGN_SEL_SEQUENCER_LOCK_EN
//     When defined, adds the lock input. Once lock is sampled high in RUN the
//     block refuses every request and ignores soft_rst until rst.
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module design_sel_sequencer #(
   parameter int             GUARD_CYCLES  = 4,
   parameter int             HOLD_CYCLES   = 16,
   parameter int             CNT_W         = 8,
   parameter logic [2:0]     DEFAULT_SEL   = 3'd0,
   parameter logic [7:0]     DISABLED_MASK = 8'h00
) (
   input  logic                         clk_i,
   input  logic                         rst,
   design_sel_sequencer_if.slave        bus,
   input  logic                         soft_rst,
`ifdef DESIGN_SEL_SEQUENCER_LOCK_EN
   input  logic                         lock,
`endif
   output logic [2:0]                   design_sel,
   output logic                         design_rst_n,
   output logic                         io_quiet,
   output logic                         busy
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_QUIESCE = 2'd1,
      ST_SWITCH  = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   // Counter load values: a phase of N cycles counts N-1 down to 0.
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       pending_sel;
   // Set when the running sequence was started by an accepted request, so the
   // return to RUN reports completion; restarts and boot stay silent.
   logic             resp_pend;

   logic             accept;
   logic             refuse;
   logic             lock_refuse;

   // req_ready is a registered copy of (state == RUN), so accept implies RUN.
   always_comb begin
      accept = 1'b0;
      refuse = 1'b0;
      accept = bus.req_valid && bus.req_ready;
      refuse = DISABLED_MASK[bus.req_sel] || lock_refuse;
   end

`ifdef DESIGN_SEL_SEQUENCER_LOCK_EN
   logic locked;

   // lock is only sampled in RUN. A request that proceeds in the same cycle
   // takes precedence; if lock is still high on the return to RUN it is
   // sampled then.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         locked <= 1'b0;
      end else if ((state == ST_RUN) && lock && !(accept && !refuse)) begin
         locked <= 1'b1;
      end
   end

   always_comb begin
      lock_refuse = 1'b0;
      lock_refuse = locked;
   end
`else
   always_comb begin
      lock_refuse = 1'b0;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst) begin
         // Boot looks like the tail of a switch to DEFAULT_SEL: HOLD with the
         // full hold time remaining, and no response at the end.
         state        <= ST_HOLD;
         cnt          <= HOLD_LOAD;
         pending_sel  <= DEFAULT_SEL;
         resp_pend    <= 1'b0;
         design_sel   <= DEFAULT_SEL;
         design_rst_n <= 1'b0;
         io_quiet     <= 1'b1;
         busy         <= 1'b1;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;

         case (state)
            // ---- RUN: design live, accepting requests ----
            ST_RUN: begin
               if (accept) begin
                  if (refuse) begin
                     // Refusal leaves select, reset and pads untouched.
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                  end else begin
                     // Accepted even when req_sel == design_sel: acts as a restart.
                     pending_sel   <= bus.req_sel;
                     resp_pend     <= 1'b1;
                     state         <= ST_QUIESCE;
                     cnt           <= GUARD_LOAD;
                     design_rst_n  <= 1'b0;
                     io_quiet      <= 1'b1;
                     busy          <= 1'b1;
                     bus.req_ready <= 1'b0;
                  end
               end else if (soft_rst && !lock_refuse) begin
                  // A request in the same cycle wins; soft_rst only reaches here
                  // when nothing was accepted.
                  pending_sel   <= design_sel;
                  resp_pend     <= 1'b0;
                  state         <= ST_QUIESCE;
                  cnt           <= GUARD_LOAD;
                  design_rst_n  <= 1'b0;
                  io_quiet      <= 1'b1;
                  busy          <= 1'b1;
                  bus.req_ready <= 1'b0;
               end
            end

            // ---- QUIESCE: old select, pads killed, design in reset ----
            ST_QUIESCE: begin
               if (cnt == CNT_ZERO) begin
                  state <= ST_SWITCH;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            // ---- SWITCH: move the mux while everything is quiet ----
            ST_SWITCH: begin
               design_sel <= pending_sel;
               state      <= ST_HOLD;
               cnt        <= HOLD_LOAD;
            end

            // ---- HOLD: new select, design still in reset ----
            ST_HOLD: begin
               if (cnt == CNT_ZERO) begin
                  state          <= ST_RUN;
                  design_rst_n   <= 1'b1;
                  io_quiet       <= 1'b0;
                  busy           <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  bus.resp_valid <= resp_pend;
                  resp_pend      <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            // Corrupted state: fall back to a safe switch to DEFAULT_SEL.
            default: begin
               state         <= ST_QUIESCE;
               cnt           <= GUARD_LOAD;
               pending_sel   <= DEFAULT_SEL;
               resp_pend     <= 1'b0;
               design_rst_n  <= 1'b0;
               io_quiet      <= 1'b1;
               busy          <= 1'b1;
               bus.req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
